// File: rtl/defaults.sv
// defaults: latches four signed operands on start and emits a fixed pair sequence, then flags done.
// Build option DEFAULTS_LOOP_CAP_EN limits the loop to MAX_ITER iterations.
module defaults #(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 16
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH-1:0] c,
  input  logic signed [WIDTH-1:0] d,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic                    _valid,
  output logic                    _done
);
  typedef enum logic [2:0] {S_IDLE, S_Y0, S_Y1, S_Y2, S_LOOP, S_DONE} state_t;
  state_t                  r_state;
  logic signed [WIDTH-1:0] r_a, r_b, r_c, r_d, r_n, r_i;
  logic signed [WIDTH-1:0] w_n, w_prod;
  logic                    w_accept;
  assign w_accept = _start && (r_state == S_IDLE || _done);
  assign w_prod   = r_a * r_i;
`ifdef DEFAULTS_LOOP_CAP_EN
  localparam logic signed [WIDTH-1:0] LP_CAP = MAX_ITER;
  assign w_n = (d > LP_CAP) ? LP_CAP : d;
`else
  assign w_n = d;
`endif
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_n     <= '0;
      r_i     <= '0;
      _out0   <= '0;
      _out1   <= '0;
      _valid  <= 1'b0;
      _done   <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_Y0;
      r_a     <= a;
      r_b     <= b;
      r_c     <= c;
      r_d     <= d;
      r_n     <= w_n;
      r_i     <= '0;
      _out0   <= a;
      _out1   <= b;
      _valid  <= 1'b1;
      _done   <= 1'b0;
    end else begin
      case (r_state)
        S_Y0: begin
          _out0   <= r_c;
          _out1   <= r_d;
          r_state <= S_Y1;
        end
        S_Y1: begin
          _out0   <= r_a + r_c;
          _out1   <= r_b + r_d;
          r_state <= S_Y2;
        end
        S_Y2: begin
          if (r_n <= 0) begin
            _valid  <= 1'b0;
            _done   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            _out0   <= '0;
            _out1   <= r_c;
            r_i     <= 1;
            r_state <= S_LOOP;
          end
        end
        S_LOOP: begin
          if (r_i == r_n) begin
            _valid  <= 1'b0;
            _done   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            _out0 <= r_i;
            _out1 <= w_prod + r_c;
            r_i   <= r_i + 1;
          end
        end
        default: _valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_defaults.sv
// tb_defaults: directed checks of the defaults pair generator.
module tb_defaults;
  logic               clk;
  logic               rst;
  logic               start;
  logic signed [31:0] ia, ib, ic, id;
  logic signed [31:0] out0, out1;
  logic               valid, done;
  int                 n_checks = 0;
  int                 n_errors = 0;
  defaults dut (
    ._clock(clk), ._reset(rst), ._start(start),
    .a(ia), .b(ib), .c(ic), .d(id),
    ._out0(out0), ._out1(out1), ._valid(valid), ._done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic signed [31:0] va, vb, vc, vd);
    ia    = va;
    ib    = vb;
    ic    = vc;
    id    = vd;
    start = 1'b1;
    tick();
    start = 1'b0;
    ia    = 32'hDEAD_0001;
    ib    = 32'hDEAD_0002;
    ic    = 32'hDEAD_0003;
    id    = 32'hDEAD_0004;
    check("done_clr", {31'b0, done}, 32'd0);
  endtask
  task automatic pair(input string tag, input logic signed [31:0] e0, e1);
    check({tag, "_v"}, {31'b0, valid}, 32'd1);
    check({tag, "_o0"}, out0, e0);
    check({tag, "_o1"}, out1, e1);
    tick();
  endtask
  task automatic fin(input string tag, input logic signed [31:0] e0, e1);
    check({tag, "_v"}, {31'b0, valid}, 32'd0);
    check({tag, "_d"}, {31'b0, done}, 32'd1);
    check({tag, "_o0"}, out0, e0);
    check({tag, "_o1"}, out1, e1);
  endtask
  initial begin
    int nloop;
    start = 1'b0;
    rst   = 1'b0;
    {ia, ib, ic, id} = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_o0", out0, 0);
    check("rst_o1", out1, 0);
    check("rst_vd", {30'b0, valid, done}, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("idle_v", {31'b0, valid}, 0);
    go(1, 2, 3, 4);
    pair("t1p0", 1, 2); pair("t1p1", 3, 4); pair("t1p2", 4, 6);
    pair("t1l0", 0, 3); pair("t1l1", 1, 4); pair("t1l2", 2, 5); pair("t1l3", 3, 6);
    fin("t1f", 3, 6);
    tick(); tick();
    fin("t1h", 3, 6);
    go(5, -1, 2, 0);
    pair("t2p0", 5, -1); pair("t2p1", 2, 0); pair("t2p2", 7, -1);
    fin("t2f", 7, -1);
    go(5, -1, 2, -3);
    pair("t3p0", 5, -1); pair("t3p1", 2, -3); pair("t3p2", 7, -4);
    fin("t3f", 7, -4);
    go(32'h7FFF_FFFF, 0, 1, 2);
    pair("t4p0", 32'h7FFF_FFFF, 0); pair("t4p1", 1, 2); pair("t4p2", 32'h8000_0000, 2);
    pair("t4l0", 0, 1); pair("t4l1", 1, 32'h8000_0000);
    fin("t4f", 1, 32'h8000_0000);
    go(-2, 7, 10, 1);
    pair("t5p0", -2, 7);
    start = 1'b1;
    pair("t5p1", 10, 1);
    pair("t5p2", 8, 8);
    start = 1'b0;
    pair("t5l0", 0, 10);
    fin("t5f", 0, 10);
    go(1, 2, 3, 4);
    pair("t6p0", 1, 2); pair("t6p1", 3, 4); pair("t6p2", 4, 6); pair("t6l0", 0, 3);
    #2 rst = 1'b1;
    #1;
    check("t6r_o0", out0, 0);
    check("t6r_o1", out1, 0);
    check("t6r_vd", {30'b0, valid, done}, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("t6r_idle", {30'b0, valid, done}, 0);
    go(2, 0, -1, 2);
    pair("t7p0", 2, 0); pair("t7p1", -1, 2); pair("t7p2", 1, 2);
    pair("t7l0", 0, -1); pair("t7l1", 1, 1);
    fin("t7f", 1, 1);
`ifdef DEFAULTS_LOOP_CAP_EN
    nloop = 16;
    go(3, 5, 1, 100);
    pair("t8p0", 3, 5); pair("t8p1", 1, 100); pair("t8p2", 4, 105);
`else
    nloop = 20;
    go(3, 5, 1, 20);
    pair("t8p0", 3, 5); pair("t8p1", 1, 20); pair("t8p2", 4, 25);
`endif
    for (int i = 0; i < nloop; i++) pair("t8l", i, 3 * i + 1);
    fin("t8f", nloop - 1, 3 * (nloop - 1) + 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/defaults.md
Name: defaults

Overview:
- Hardware generator block: on a start pulse it latches four signed operands, then emits a fixed sequence of value pairs, one pair per cycle.
- It raises a done flag when the sequence ends.
- Sits behind a simple start/done control interface and feeds downstream consumers that sample `_out0`/`_out1` whenever `_valid` is high.

Parameters:
- WIDTH, 32, bit width of all operands and outputs (two's-complement signed)
- MAX_ITER, 16, loop iteration cap; used only when DEFAULTS_LOOP_CAP_EN is defined

Ports:
- _clock  input  1  single clock; all state updates on rising edge
- _reset  input  1  asynchronous, active-high reset
- _start  input  1  start request, sampled on rising edge
- a  input  WIDTH  signed operand
- b  input  WIDTH  signed operand
- c  input  WIDTH  signed operand
- d  input  WIDTH  signed operand; also the loop count
- _out0  output  WIDTH  signed first element of current pair (registered)
- _out1  output  WIDTH  signed second element of current pair (registered)
- _valid  output  1  high for exactly the cycles in which `_out0`/`_out1` hold a new pair
- _done  output  1  high once the sequence completes; holds until next accepted start

Behaviour:
- Interface: one clock `_clock`; reset `_reset` is asynchronous and active-high.
- Reset values: `_out0`=0, `_out1`=0, `_valid`=0, `_done`=0, state=IDLE, all internal registers 0.
- Start acceptance:
  - `_start` is accepted in IDLE, or when `_done`=1.
  - On that edge a, b, c, d are latched; later input changes are ignored until the next start.
  - `_done` clears on the same edge.
- Latency: the first pair is registered on the accepting edge, so `_valid`=1 in the following cycle.
- Sequence, one pair per cycle, using the latched values, with `_valid`=1 on each:
  - Y0: (a, b)
  - Y1: (c, d)
  - Y2: (a+c, b+d)
  - LOOP: for i = 0 .. d-1, emit (i, a*i + c)
- Loop bounds: if d <= 0 (signed compare), LOOP is skipped entirely.
- States: IDLE -> Y0 -> Y1 -> Y2 -> LOOP (i increments each cycle) -> DONE. Y2 goes straight to DONE when d <= 0.
- DONE:
  - On entry, `_done`=1 and `_valid`=0.
  - `_out0`/`_out1` hold the last emitted pair.
  - Stays in DONE until a start is accepted, which begins a new run at Y0.
- Arithmetic: all sums and products are signed and wrap modulo 2^WIDTH. The product a*i is truncated to WIDTH bits before adding c. No overflow flag.
- Start while busy: `_start` in Y0/Y1/Y2/LOOP is ignored and the run continues unaffected.
- Reset mid-run: returns to reset values immediately (asynchronous); no partial pair follows.
- Outputs change only on a rising `_clock` edge, or on `_reset` assertion.

Optional Feature:
- Macro: DEFAULTS_LOOP_CAP_EN.
- When defined: the LOOP iteration count is min(d, MAX_ITER) for d > 0, bounding run length to 3+MAX_ITER pairs.
- When undefined: LOOP runs exactly d iterations (up to 2^(WIDTH-1)-1) and MAX_ITER is unused.
- All other behaviour is identical in both builds.

Test Plan:
- a=1, b=2, c=3, d=4, single start pulse -> `_valid` pairs (1,2),(3,4),(4,6),(0,3),(1,4),(2,5),(3,6); then `_done`=1, `_valid`=0, outputs hold (3,6) for the remaining cycles.
- d=0 (a=5, b=-1, c=2) -> pairs (5,-1),(2,0),(7,-1), then `_done`=1. Repeat with d=-3 -> same behaviour, no loop pairs.
- Wrap: a=32'h7FFFFFFF, c=1, b=0, d=2 -> third pair `_out0`=32'h80000000 (negative); loop pairs (0,1),(1,32'h80000000).
- Restart after done with a=-2, b=7, c=10, d=1 -> `_done` drops on the accepting edge; pairs (-2,7),(10,1),(8,8),(0,10); `_done`=1 again. `_start` pulsed during the run is ignored.
- Assert `_reset` during LOOP -> outputs/`_valid`/`_done` go to 0 without waiting for a clock edge; a subsequent start runs a full, fresh sequence.
- With DEFAULTS_LOOP_CAP_EN, MAX_ITER=16, d=100 -> exactly 3+16 = 19 valid pairs, last pair (15, a*15+c), then `_done`=1.
